// File: rtl/pipe_arbiter_pkg.sv
// Shared types and constants for the two-requester PIPE arbiter.
package pipe_pkg;

    localparam int DW        = 6;
    localparam int OW        = 27;
    localparam int PIPE_LAT  = 4;
    localparam int TAG_DEPTH = PIPE_LAT + 1;
    localparam int BLANK_W   = $clog2(TAG_DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_MUL2 = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_MUL4 = 2'b10,
        MODE_BAD  = 2'b11
    } mode_t;

    typedef enum logic {
        ID_A = 1'b0,
        ID_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic    live;
        req_id_t id;
        logic    err;
    } tag_t;

    typedef struct packed {
        logic [DW-1:0] in1;
        logic [DW-1:0] in2;
        logic [DW-1:0] in3;
        logic [DW-1:0] in4;
        mode_t         mode;
    } op_t;

    function automatic logic is_bad_mode(mode_t m);
        return m == MODE_BAD;
    endfunction

endpackage

// File: rtl/pipe_arbiter_if.sv
// Requester, PIPE and response signals of the arbiter; slave is the arbiter's view.
interface pipe_arbiter_if;

    logic                    a_valid;
    logic                    a_ready;
    logic [pipe_pkg::DW-1:0] a_in1;
    logic [pipe_pkg::DW-1:0] a_in2;
    logic [pipe_pkg::DW-1:0] a_in3;
    logic [pipe_pkg::DW-1:0] a_in4;
    logic [1:0]              a_mode;

    logic                    b_valid;
    logic                    b_ready;
    logic [pipe_pkg::DW-1:0] b_in1;
    logic [pipe_pkg::DW-1:0] b_in2;
    logic [pipe_pkg::DW-1:0] b_in3;
    logic [pipe_pkg::DW-1:0] b_in4;
    logic [1:0]              b_mode;

    logic                    pipe_in_valid;
    logic [pipe_pkg::DW-1:0] pipe_in1;
    logic [pipe_pkg::DW-1:0] pipe_in2;
    logic [pipe_pkg::DW-1:0] pipe_in3;
    logic [pipe_pkg::DW-1:0] pipe_in4;
    logic [1:0]              pipe_mode;
    logic                    pipe_out_valid;
    logic [pipe_pkg::OW-1:0] pipe_out_value;

    logic                    a_rsp_valid;
    logic                    b_rsp_valid;
    logic [pipe_pkg::OW-1:0] rsp_value;
    logic                    rsp_err;
    logic                    seq_err;

    modport slave (
        input  a_valid, a_in1, a_in2, a_in3, a_in4, a_mode,
        input  b_valid, b_in1, b_in2, b_in3, b_in4, b_mode,
        input  pipe_out_valid, pipe_out_value,
        output a_ready, b_ready,
        output pipe_in_valid, pipe_in1, pipe_in2, pipe_in3, pipe_in4, pipe_mode,
        output a_rsp_valid, b_rsp_valid, rsp_value, rsp_err, seq_err
    );

    modport master (
        output a_valid, a_in1, a_in2, a_in3, a_in4, a_mode,
        output b_valid, b_in1, b_in2, b_in3, b_in4, b_mode,
        output pipe_out_valid, pipe_out_value,
        input  a_ready, b_ready,
        input  pipe_in_valid, pipe_in1, pipe_in2, pipe_in3, pipe_in4, pipe_mode,
        input  a_rsp_valid, b_rsp_valid, rsp_value, rsp_err, seq_err
    );

endinterface

// File: rtl/pipe_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names who wins the next tie.
module pipe_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    logic prio_b;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            if (req_a && (!req_b || !prio_b)) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    // Pointer only moves on a grant, handing priority to the other side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_b <= 1'b0;
        end else if (gnt_a) begin
            prio_b <= 1'b1;
        end else if (gnt_b) begin
            prio_b <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_arbiter.sv
// Shares one PIPE datapath between requesters A and B, routing results back by tag.
module pipe_arbiter
    import pipe_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    pipe_arbiter_if.slave bus
);

    logic gnt_a;
    logic gnt_b;
    logic gnt;
    logic sel_bad;

    op_t op_a;
    op_t op_b;
    op_t op_sel;

    logic issue_valid;
    op_t  issue_op;

    tag_t tag_q [TAG_DEPTH];
    tag_t tag_new;
    tag_t head;
    logic head_ok;

    logic [BLANK_W-1:0] blank_q;
    logic               mismatch;

    logic          a_rsp_q;
    logic          b_rsp_q;
    logic [OW-1:0] rsp_value_q;
    logic          rsp_err_q;
    logic          seq_err_q;

    pipe_rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_a (bus.a_valid),
        .req_b (bus.b_valid),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign bus.a_ready = gnt_a;
    assign bus.b_ready = gnt_b;
    assign gnt         = gnt_a | gnt_b;

    always_comb begin
        op_a = '{in1: bus.a_in1, in2: bus.a_in2, in3: bus.a_in3, in4: bus.a_in4,
                 mode: mode_t'(bus.a_mode)};
        op_b = '{in1: bus.b_in1, in2: bus.b_in2, in3: bus.b_in3, in4: bus.b_in4,
                 mode: mode_t'(bus.b_mode)};
        op_sel  = gnt_b ? op_b : op_a;
        sel_bad = is_bad_mode(op_sel.mode);
    end

    // Unsupported ops never reach PIPE; operands hold when nothing issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid <= 1'b0;
            issue_op    <= '0;
        end else begin
            issue_valid <= gnt & ~sel_bad;
            if (gnt && !sel_bad) begin
                issue_op <= op_sel;
            end
        end
    end

    assign bus.pipe_in_valid = issue_valid;
    assign bus.pipe_in1      = issue_op.in1;
    assign bus.pipe_in2      = issue_op.in2;
    assign bus.pipe_in3      = issue_op.in3;
    assign bus.pipe_in4      = issue_op.in4;
    assign bus.pipe_mode     = issue_op.mode;

    always_comb begin
        tag_new = '{live: gnt, id: (gnt_b ? ID_B : ID_A), err: gnt & sel_bad};
    end

    // One stage more than PIPE_LAT covers the issue register in front of PIPE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_new;
            for (int i = 1; i < TAG_DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign head     = tag_q[TAG_DEPTH-1];
    assign head_ok  = head.live & ~head.err;
    assign mismatch = head_ok ^ bus.pipe_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= BLANK_W'(TAG_DEPTH);
        end else if (blank_q != '0) begin
            blank_q <= blank_q - BLANK_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_err_q <= 1'b0;
        end else if (mismatch && (blank_q == '0)) begin
            seq_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rsp_q     <= 1'b0;
            b_rsp_q     <= 1'b0;
            rsp_value_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            a_rsp_q     <= head.live & (head.id == ID_A);
            b_rsp_q     <= head.live & (head.id == ID_B);
            rsp_value_q <= head_ok ? bus.pipe_out_value : '0;
            rsp_err_q   <= head.live & head.err;
        end
    end

    assign bus.a_rsp_valid = a_rsp_q;
    assign bus.b_rsp_valid = b_rsp_q;
    assign bus.rsp_value   = rsp_value_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.seq_err     = seq_err_q;

endmodule

// File: doc/pipe_arbiter.md
Name: pipe_arbiter

Overview:
Shares one PIPE arithmetic datapath between two requesters, A and B.
- Arbitrates requests round-robin and issues at most one operation per cycle into PIPE through a registered issue stage.
- Tracks each in-flight operation's owner in a tag shift register and routes every PIPE result back to its requester.
- Rejects the unsupported mode 2'b11 in-band with an error response, and flags any misalignment between tags and PIPE results.

Parameters:
- PIPE_LAT, 4, PIPE latency in cycles from in_valid sampled to out_valid.
- DW, 6, operand width.
- OW, 27, result width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- a_valid  in  1  requester A has an operation.
- a_ready  out  1  A handshake this cycle (combinational grant).
- a_in1..a_in4  in  DW each  A operands.
- a_mode  in  2  A mode.
- b_valid, b_ready, b_in1..b_in4, b_mode  same as A, for requester B.
- pipe_in_valid  out  1  to PIPE in_valid.
- pipe_in1..pipe_in4  out  DW each  to PIPE in_1..in_4.
- pipe_mode  out  2  to PIPE mode.
- pipe_out_valid  in  1  from PIPE out_valid.
- pipe_out_value  in  OW  from PIPE out_value.
- a_rsp_valid  out  1  one-cycle result pulse to A; no backpressure.
- b_rsp_valid  out  1  one-cycle result pulse to B; no backpressure.
- rsp_value  out  OW  result, shared by both requesters.
- rsp_err  out  1  result is an error (mode 2'b11).
- seq_err  out  1  sticky tag/result mismatch flag.

Behaviour:
- Reset values:
  - All outputs 0.
  - Round-robin pointer points at A.
  - Tag shift register cleared.
  - Blank counter loaded with PIPE_LAT+1.
- PIPE reset: the top level drives PIPE rst_n = ~rst, so both blocks reset together.
- Arbitration:
  - Only one valid: it is granted.
  - Both valid: grant the requester not granted last; the pointer updates only on a grant.
  - x_ready is high exactly when x is granted.
  - At most one grant per cycle; a never blocks b and vice versa.
- Issue stage, for a grant at cycle T:
  - Mode 2'b11: pipe_in_valid=0 at T+1 and nothing enters PIPE.
  - Other modes: at T+1, pipe_in_valid=1 and pipe_in*/pipe_mode carry the granted operands.
  - No grant: pipe_in_valid=0 with operands held.
- Tag shift register:
  - PIPE_LAT+1 stages; each entry is {live, id, err}.
  - Entry pushed at T, shifted every cycle; the head aligns with PIPE out_valid at T+PIPE_LAT+1.
- Response, registered, at T+PIPE_LAT+2 (6 cycles by default):
  - Head live and id=A: a_rsp_valid=1 (likewise b_rsp_valid for id=B).
  - rsp_value = pipe_out_value, or 0 when err=1.
  - rsp_err = head err.
  - Responses are strictly in grant order.
- Response values by mode:
  - 00: in1*in2
  - 01: in3+in4
  - 10: (in1*in2)*(in3*in4)
  - 11: err.
- Full throughput: back-to-back grants every cycle are legal, because PIPE is fully pipelined.
- seq_err:
  - Sets when the head is live with err=0 and pipe_out_valid=0.
  - Sets when pipe_out_valid=1 and the head is not live-and-non-err.
  - Cleared only by rst.
- Blank window: the check is disabled while the blank counter is nonzero. The counter decrements every cycle after reset release, which masks stale PIPE valids.
- Reset mid-operation:
  - Asserting rst immediately drops all in-flight operations; no responses are ever produced for them.
  - Grants are still allowed during the blank window.
- Simultaneous grant and response: independent; both occur in the same cycle.

Decomposition:
- Package pipe_pkg holds:
  - mode enum: MODE_MUL2=2'b00, MODE_ADD=2'b01, MODE_MUL4=2'b10, MODE_BAD=2'b11.
  - tag_t struct {live, id, err}.
  - Constants DW, OW, PIPE_LAT.
- One natural sub-module: pipe_rr_arb2, a 2-way round-robin arbiter with pointer register.
- The tag shift register and issue register stay inline.

Test Plan:
- A only, mode 00, in1=5, in2=7, granted at T -> a_rsp_valid=1 at T+6, rsp_value=35, rsp_err=0.
- B only, mode 01, in3=10, in4=20 -> b_rsp_valid at T+6, rsp_value=30.
- A mode 10 with all operands 63 -> rsp_value=15752961.
- A and B both valid for 4 cycles with distinct operands:
  - Grants alternate A,B,A,B.
  - Responses follow on consecutive cycles with correct owners and values.
  - seq_err stays 0.
- A mode 11 between two valid ops:
  - pipe_in_valid=0 in its issue slot.
  - Error response at T+6 with a_rsp_valid=1, rsp_err=1, rsp_value=0.
  - Neighbouring responses are unaffected.
- Two operations in flight, then rst pulsed:
  - No response ever appears for them.
  - seq_err stays 0 through the blank window.
  - A forced stray pipe_out_valid after the window sets seq_err=1, which holds until the next rst.
